ppu_palette_loader: RTL

Parametrised palette fetch engine for the PPU. It reads a contiguous range of palette entries out of VRAM over a request/grant bus and stores them in an on-block register file. The file is exported as a flat bus to the pixel pipeline. It supports partial reloads, a configurable VRAM read latency, bus-grant stalls, and optional NES sprite/background entry mirroring.

---
 rtl/ppu_pkg.sv | 20 ++
 rtl/ppu_tag_pipe.sv | 41 ++++
 rtl/ppu_palette_loader.sv | 134 +++++++++++++
 3 files changed

// File: rtl/ppu_pkg.sv
// Shared PPU types and constants: loader FSM states, palette base address and size.
// pal_mirror_idx folds NES sprite backdrop entries 16/20/24/28 onto 0/4/8/12.
package ppu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } pal_state_t;

    localparam logic [15:0] PPU_PALETTE_BASE    = 16'h3F00;
    localparam int          PPU_PALETTE_ENTRIES = 32;

    function automatic int pal_mirror_idx(input int idx);
        return ((idx & 'h13) == 'h10) ? (idx & ~'h10) : idx;
    endfunction

endpackage

// File: rtl/ppu_tag_pipe.sv
// Fixed-latency valid+tag shift register that tracks reads in flight.
// flush clears every valid bit so aborted reads never land.
module ppu_tag_pipe #(
    parameter int DEPTH = 1,
    parameter int W     = 5
) (
    input  logic         clk,
    input  logic         flush,
    input  logic         push_vld,
    input  logic [W-1:0] push_tag,
    output logic         out_vld,
    output logic [W-1:0] out_tag,
    output logic         any_valid
);

    logic [DEPTH-1:0] vld;
    logic [W-1:0]     tag [DEPTH];

    always_ff @(posedge clk) begin
        if (flush) begin
            vld <= '0;
        end else begin
            vld[0] <= push_vld;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        tag[0] <= push_tag;
        for (int i = 1; i < DEPTH; i++) begin
            tag[i] <= tag[i-1];
        end
    end

    assign out_vld   = vld[DEPTH-1];
    assign out_tag   = tag[DEPTH-1];
    assign any_valid = |vld;

endmodule

// File: rtl/ppu_palette_loader.sv
// Palette fetch engine: streams a (wrapping) range of VRAM entries into a register file.
// Define PPU_PALETTE_MIRROR_EN for NES mirroring of entries 16/20/24/28 onto 0/4/8/12.
module ppu_palette_loader
    import ppu_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR    = PPU_PALETTE_BASE,
    parameter int          NUM_ENTRIES  = PPU_PALETTE_ENTRIES,
    parameter int          ENTRY_W      = 8,
    parameter int          READ_LATENCY = 1,
    parameter int          IDX_W        = $clog2(NUM_ENTRIES)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [IDX_W-1:0]               start_idx,
    input  logic [IDX_W:0]                 count,
    output logic                           vram_req,
    input  logic                           vram_gnt,
    output logic [15:0]                    vram_addr,
    output logic                           vram_addr_vld,
    input  logic [7:0]                     vram_data_in,
    output logic                           busy,
    output logic                           done,
    output logic [NUM_ENTRIES*ENTRY_W-1:0] palette
);

    localparam logic [IDX_W:0] MAX_CNT = (IDX_W+1)'(NUM_ENTRIES);

    pal_state_t       state;
    pal_state_t       state_nxt;
    logic [IDX_W-1:0] cur_idx;
    logic [IDX_W:0]   remaining;
    logic [IDX_W:0]   cnt_clamped;
    logic             consume;
    logic             pipe_vld;
    logic [IDX_W-1:0] pipe_tag;
    logic             pipe_busy;
    logic [IDX_W-1:0] wr_idx;
    logic [ENTRY_W-1:0] store [NUM_ENTRIES];

    assign cnt_clamped = (count > MAX_CNT) ? MAX_CNT : count;
    assign consume     = (state == ST_ISSUE) && vram_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (cnt_clamped == '0) ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                if (vram_gnt) state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (consume && remaining == 1) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!pipe_busy) state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        vram_req      = (state == ST_REQ) || (state == ST_ISSUE);
        vram_addr_vld = (state == ST_ISSUE);
        busy          = (state != ST_IDLE);
        done          = (state == ST_DONE);
        vram_addr     = BASE_ADDR + 16'(cur_idx);
    end

    // cur_idx is IDX_W wide, so the increment wraps modulo NUM_ENTRIES
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_idx   <= '0;
            remaining <= '0;
        end else if (state == ST_IDLE && start) begin
            cur_idx   <= start_idx;
            remaining <= cnt_clamped;
        end else if (consume) begin
            cur_idx   <= cur_idx + 1'b1;
            remaining <= remaining - 1'b1;
        end
    end

    ppu_tag_pipe #(
        .DEPTH (READ_LATENCY),
        .W     (IDX_W)
    ) u_tag_pipe (
        .clk       (clk),
        .flush     (rst),
        .push_vld  (consume),
        .push_tag  (cur_idx),
        .out_vld   (pipe_vld),
        .out_tag   (pipe_tag),
        .any_valid (pipe_busy)
    );

`ifdef PPU_PALETTE_MIRROR_EN
    assign wr_idx = IDX_W'(pal_mirror_idx(int'(pipe_tag)));
`else
    assign wr_idx = pipe_tag;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                store[i] <= '0;
            end
        end else if (pipe_vld) begin
            store[wr_idx] <= vram_data_in[ENTRY_W-1:0];
        end
    end

    for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_out
`ifdef PPU_PALETTE_MIRROR_EN
        localparam int SRC = pal_mirror_idx(g);
`else
        localparam int SRC = g;
`endif
        assign palette[g*ENTRY_W +: ENTRY_W] = store[SRC];
    end

endmodule
